// File: rtl/qmfir_uart_cmd_parser.sv
// Host command-frame parser: turns UART bytes into QM-FIR register/BRAM bus
// writes and reads, and streams 24-bit read data back as three bytes.
module qmfir_uart_cmd_parser #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd173600,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [23:0] uart_mem_i,
    input  logic [23:0] uart_reg_i,
    output logic [13:0] uart_addr,
    output logic [31:0] uart_dout,
    output logic        uart_mem_we,
    output logic        uart_mem_re,
    output logic        reg_we,
    output logic        busy,
    output logic        err_ovf,
    output logic        err_tout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_EXEC    = 3'd3,
        S_RD_WAIT = 3'd4,
        S_TX      = 3'd5
    } state_t;

    localparam logic [2:0]  RD_LAT_M1  = 3'(RD_LAT - 1);
    localparam logic [19:0] GAP_EXPIRY = TIMEOUT_CYC - 20'd1;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [13:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [19:0] gap_q, gap_d;
    logic [2:0]  rd_cnt_q, rd_cnt_d;
    logic [23:0] rd_buf_q, rd_buf_d;
    logic [1:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [13:0] uart_addr_q, uart_addr_d;
    logic [31:0] uart_dout_q, uart_dout_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;
    logic        reg_we_q, reg_we_d;
    logic        busy_q, busy_d;
    logic        err_ovf_q, err_ovf_d;
    logic        err_tout_q, err_tout_d;
    logic [23:0] rd_word;

    // Next-state and registered-output computation for the frame FSM.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        byte_cnt_d  = byte_cnt_q;
        gap_d       = gap_q;
        rd_cnt_d    = rd_cnt_q;
        rd_buf_d    = rd_buf_q;
        tx_idx_d    = tx_idx_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        uart_addr_d = uart_addr_q;
        uart_dout_d = uart_dout_q;
        mem_we_d    = 1'b0;
        reg_we_d    = 1'b0;
        mem_re_d    = mem_re_q;
        err_ovf_d   = err_ovf_q;
        err_tout_d  = err_tout_q;
        rd_word     = op_q[0] ? uart_mem_i : uart_reg_i;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    op_d          = rx_data[7:6];
                    addr_d[13:8]  = rx_data[5:0];
                    gap_d         = 20'd0;
                    state_d       = S_ADDR;
                end else begin
                    gap_d = 20'd0;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d[7:0] = rx_data;
                    gap_d       = 20'd0;
                    if (op_q[1] == 1'b0) begin
                        byte_cnt_d = 2'd0;
                        state_d    = S_DATA;
                    end else begin
                        rd_cnt_d    = 3'd0;
                        uart_addr_d = {addr_q[13:8], rx_data};
                        mem_re_d    = (op_q == 2'b11);
                        state_d     = S_RD_WAIT;
                    end
                end else if (gap_q == GAP_EXPIRY) begin
                    err_tout_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    gap_d = gap_q + 20'd1;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    data_d     = {data_q[23:0], rx_data};
                    gap_d      = 20'd0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        uart_addr_d = addr_q;
                        uart_dout_d = {data_q[23:0], rx_data};
                        reg_we_d    = (op_q == 2'b00);
                        mem_we_d    = (op_q == 2'b01);
                        state_d     = S_EXEC;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (gap_q == GAP_EXPIRY) begin
                    err_tout_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    gap_d = gap_q + 20'd1;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
            end
            S_RD_WAIT: begin
                if (rx_valid) begin
                    err_ovf_d = 1'b1;
                end else begin
                    err_ovf_d = err_ovf_q;
                end
                // Read data is sampled on the last wait cycle so the first byte is
                // presented RD_LAT+1 clocks after the second address byte.
                if (rd_cnt_q == RD_LAT_M1) begin
                    rd_buf_d   = rd_word;
                    tx_data_d  = rd_word[23:16];
                    tx_valid_d = 1'b1;
                    tx_idx_d   = 2'd0;
                    mem_re_d   = 1'b0;
                    state_d    = S_TX;
                end else begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                end
            end
            S_TX: begin
                if (rx_valid) begin
                    err_ovf_d = 1'b1;
                end else begin
                    err_ovf_d = err_ovf_q;
                end
                if (tx_valid_q && tx_ready) begin
                    if (tx_idx_q == 2'd2) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else if (tx_idx_q == 2'd0) begin
                        tx_idx_d  = 2'd1;
                        tx_data_d = rd_buf_q[15:8];
                    end else begin
                        tx_idx_d  = 2'd2;
                        tx_data_d = rd_buf_q[7:0];
                    end
                end else begin
                    tx_idx_d = tx_idx_q;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                mem_re_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            addr_q      <= 14'd0;
            data_q      <= 32'd0;
            byte_cnt_q  <= 2'd0;
            gap_q       <= 20'd0;
            rd_cnt_q    <= 3'd0;
            rd_buf_q    <= 24'd0;
            tx_idx_q    <= 2'd0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            uart_addr_q <= 14'd0;
            uart_dout_q <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_tout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_q       <= gap_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_buf_q    <= rd_buf_d;
            tx_idx_q    <= tx_idx_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            uart_addr_q <= uart_addr_d;
            uart_dout_q <= uart_dout_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
            err_ovf_q   <= err_ovf_d;
            err_tout_q  <= err_tout_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign uart_addr   = uart_addr_q;
    assign uart_dout   = uart_dout_q;
    assign uart_mem_we = mem_we_q;
    assign uart_mem_re = mem_re_q;
    assign reg_we      = reg_we_q;
    assign busy        = busy_q;
    assign err_ovf     = err_ovf_q;
    assign err_tout    = err_tout_q;

endmodule

// File: tb/tb_qmfir_uart_cmd_parser.sv
// Bench for qmfir_uart_cmd_parser: frame table plus scoreboard of expected
// bus writes and transmitted bytes, with hand sequences for stall/overflow/timeout/reset.
module tb_qmfir_uart_cmd_parser;

    localparam int T_OUT = 40;
    localparam int RDL   = 2;

    logic        clk = 1'b0;
    logic        arst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [23:0] uart_mem_i;
    logic [23:0] uart_reg_i;
    logic [13:0] uart_addr;
    logic [31:0] uart_dout;
    logic        uart_mem_we;
    logic        uart_mem_re;
    logic        reg_we;
    logic        busy;
    logic        err_ovf;
    logic        err_tout;

    qmfir_uart_cmd_parser #(.TIMEOUT_CYC(20'd40), .RD_LAT(RDL)) dut (
        .clk(clk), .arst(arst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .uart_mem_i(uart_mem_i), .uart_reg_i(uart_reg_i), .uart_addr(uart_addr),
        .uart_dout(uart_dout), .uart_mem_we(uart_mem_we), .uart_mem_re(uart_mem_re),
        .reg_we(reg_we), .busy(busy), .err_ovf(err_ovf), .err_tout(err_tout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [13:0] addr;
        logic [31:0] dout;
    } wr_exp_t;

    typedef struct {
        logic [47:0] bytes;
        int          n;
        logic [23:0] rd_val;
        logic [13:0] exp_addr;
        logic [31:0] exp_dout;
    } vec_t;

    wr_exp_t     wq[$];
    logic [7:0]  tq[$];
    wr_exp_t     mon_e;
    logic [7:0]  mon_b;
    logic [13:0] exp_rd_addr;
    int          re_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_txv(input int budget);
        int k = 0;
        while (!tx_valid && k < budget) begin
            tick();
            k++;
        end
        chk("txv_timeout", {31'd0, tx_valid}, 32'd1);
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from input changes.
    always @(negedge clk) begin
        if (int'(reg_we) + int'(uart_mem_we) + int'(uart_mem_re) > 1) begin
            chk("bus_exclusive", 32'd1, 32'd0);
        end
        if (!busy && (reg_we || uart_mem_we || uart_mem_re)) begin
            chk("idle_bus", 32'd1, 32'd0);
        end
        if (reg_we || uart_mem_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {18'd0, uart_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = wq.pop_front();
                chk("wr_sel", {30'd0, reg_we, uart_mem_we}, (mon_e.op == 2'b00) ? 32'd2 : 32'd1);
                chk("wr_addr", {18'd0, uart_addr}, {18'd0, mon_e.addr});
                chk("wr_dout", uart_dout, mon_e.dout);
            end
        end
        if (tx_valid && tx_ready) begin
            if (tq.size() == 0) begin
                chk("unexpected_tx", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                mon_b = tq.pop_front();
                chk("tx_byte", {24'd0, tx_data}, {24'd0, mon_b});
            end
        end
        if (uart_mem_re) begin
            re_cnt++;
            chk("rd_addr", {18'd0, uart_addr}, {18'd0, exp_rd_addr});
        end
    end

    initial begin
        vecs[0] = '{48'h0003_0000_8005, 6, 24'h000000, 14'h0003, 32'h0000_8005};
        vecs[1] = '{48'h4120_DEAD_BEEF, 6, 24'h000000, 14'h0120, 32'hDEAD_BEEF};
        vecs[2] = '{48'hC805_0000_0000, 2, 24'h00ABCD, 14'h0805, 32'h0};
        vecs[3] = '{48'h8001_0000_0000, 2, 24'h001234, 14'h0001, 32'h0};
        vecs[4] = '{48'h3FFF_1234_5678, 6, 24'h000000, 14'h3FFF, 32'h1234_5678};
        vecs[5] = '{48'hFFFF_0000_0000, 2, 24'h5AC381, 14'h3FFF, 32'h0};
        vecs[6] = '{48'h4000_0000_0001, 6, 24'h000000, 14'h0000, 32'h0000_0001};

        arst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        uart_mem_i = 24'h0; uart_reg_i = 24'h0; exp_rd_addr = 14'h0; re_cnt = 0;
        #2;
        chk("rst_outs", {tx_valid, uart_mem_we, uart_mem_re, reg_we, busy, err_ovf, err_tout},
            32'd0);
        chk("rst_bus", {uart_addr, tx_data} | 32'(uart_dout), 32'd0);
        tick(); tick();
        arst = 1'b0;
        tick();

        // Table of frames: writes checked at the strobe, reads at each tx handshake.
        for (int i = 0; i < 7; i++) begin
            logic [1:0] op;
            op = vecs[i].bytes[47:46];
            uart_mem_i = vecs[i].rd_val;
            uart_reg_i = vecs[i].rd_val;
            exp_rd_addr = vecs[i].exp_addr;
            re_cnt = 0;
            tx_ready = 1'b1;
            if (!op[1]) begin
                wq.push_back('{op, vecs[i].exp_addr, vecs[i].exp_dout});
            end else begin
                tq.push_back(vecs[i].rd_val[23:16]);
                tq.push_back(vecs[i].rd_val[15:8]);
                tq.push_back(vecs[i].rd_val[7:0]);
            end
            for (int b = 0; b < vecs[i].n; b++) begin
                send_byte(vecs[i].bytes[47 - 8*b -: 8]);
            end
            if (!op[1]) begin
                chk("wr_latency", {31'd0, op[0] ? uart_mem_we : reg_we}, 32'd1);
            end else begin
                for (int k = 0; k < RDL; k++) begin
                    chk("rd_early_txv", {31'd0, tx_valid}, 32'd0);
                    tick();
                end
                chk("rd_latency", {31'd0, tx_valid}, 32'd1);
            end
            wait_idle(50);
            chk("vec_drain", wq.size() + tq.size(), 32'd0);
            if (op[1]) begin
                chk("re_cycles", re_cnt, op[0] ? RDL : 0);
            end
        end

        // Stall on second tx byte.
        tx_ready = 1'b0;
        uart_mem_i = 24'h00ABCD;
        exp_rd_addr = 14'h0805;
        tq.push_back(8'h00); tq.push_back(8'hAB); tq.push_back(8'hCD);
        send_byte(8'hC8); send_byte(8'h05);
        wait_txv(20);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("stall_data", {23'd0, tx_valid, tx_data}, 32'h1AB);
            tick();
        end
        tx_ready = 1'b1;
        wait_idle(20);
        chk("stall_drain", tq.size(), 32'd0);

        // Byte arriving during TX is dropped and flagged.
        chk("ovf_pre", {31'd0, err_ovf}, 32'd0);
        tx_ready = 1'b0;
        uart_reg_i = 24'h001234;
        tq.push_back(8'h00); tq.push_back(8'h12); tq.push_back(8'h34);
        send_byte(8'h80); send_byte(8'h01);
        wait_txv(20);
        send_byte(8'h55);
        chk("ovf_flag", {29'd0, err_ovf, busy, tx_valid}, 32'd7);
        chk("ovf_data", {24'd0, tx_data}, 32'h00);
        tx_ready = 1'b1;
        wait_idle(20);
        chk("ovf_drain", tq.size(), 32'd0);
        wq.push_back('{2'b00, 14'h0007, 32'h1122_3344});
        send_byte(8'h00); send_byte(8'h07); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_idle(20);
        chk("ovf_next_frame", wq.size(), 32'd0);

        // Timeout: abort exactly T_OUT cycles after the last byte strobe.
        send_byte(8'h00); send_byte(8'h03);
        idle(T_OUT - 1);
        chk("tout_before", {30'd0, busy, err_tout}, 32'd2);
        tick();
        chk("tout_after", {30'd0, busy, err_tout}, 32'd1);
        wq.push_back('{2'b01, 14'h0120, 32'hCAFE_F00D});
        send_byte(8'h41); send_byte(8'h20); send_byte(8'hCA);
        send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
        wait_idle(20);
        chk("tout_next_frame", wq.size(), 32'd0);

        // Byte landing on the expiry cycle wins.
        wq.push_back('{2'b00, 14'h0003, 32'hAABB_CCDD});
        send_byte(8'h00); send_byte(8'h03);
        idle(T_OUT - 1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        wait_idle(20);
        chk("expiry_accept", wq.size(), 32'd0);

        // Reset during transmit drops tx_valid at once.
        tx_ready = 1'b0;
        uart_mem_i = 24'h00ABCD;
        exp_rd_addr = 14'h0805;
        send_byte(8'hC8); send_byte(8'h05);
        wait_txv(20);
        arst = 1'b1;
        #1;
        chk("rst_tx", {tx_valid, busy, err_ovf, err_tout}, 32'd0);
        chk("rst_tx_addr", {18'd0, uart_addr}, 32'd0);
        tick();
        arst = 1'b0;
        tx_ready = 1'b1;
        tick();

        // Reset after 3 of 6 write bytes discards the frame.
        send_byte(8'h41); send_byte(8'h20); send_byte(8'hDE);
        arst = 1'b1;
        #1;
        chk("rst_mid_frame", {uart_mem_we, reg_we, busy}, 32'd0);
        tick();
        arst = 1'b0;
        tick();
        wq.push_back('{2'b00, 14'h0003, 32'h0000_8005});
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h80); send_byte(8'h05);
        wait_idle(20);
        chk("rst_next_frame", wq.size(), 32'd0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qmfir_uart_cmd_parser.md
Name: qmfir_uart_cmd_parser

Overview:
Command-frame parser between the UART byte receiver/transmitter and the QM-FIR register/BRAM bus. It assembles host command frames from received bytes and issues register or input-BRAM writes and reads. It returns read data to the host as bytes through the transmitter handshake, and drives the same bus the host interface presents to iReg and the input BRAM.

Parameters:
TIMEOUT_CYC, 20'd173600, idle clocks allowed between bytes of one frame before the frame is aborted (about 20 byte times at 115200 baud, 100 MHz).
RD_LAT, 2, clocks from read-address valid to read data valid on uart_mem_i/uart_reg_i (range 1..7).

Ports:
clk  in  1  system clock
arst  in  1  asynchronous reset, active-high
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
uart_mem_i  in  24  BRAM read data
uart_reg_i  in  24  register read data
uart_addr  out  14  bus address
uart_dout  out  32  bus write data
uart_mem_we  out  1  BRAM write strobe
uart_mem_re  out  1  BRAM read enable
reg_we  out  1  register write strobe
busy  out  1  high in every state except IDLE
err_ovf  out  1  sticky: byte received while in RD_WAIT/TX
err_tout  out  1  sticky: frame aborted by timeout

Behaviour:
- Reset (async, arst=1): all outputs 0, state IDLE, counters 0. Reset mid-frame discards the frame. Reset mid-transmit drops tx_valid immediately.
- Frame format: byte0 = {op[1:0], addr[13:8]}, byte1 = addr[7:0]. Write ops are followed by 4 data bytes, MSB first.
- op encoding: 00 reg write, 01 mem write, 10 reg read, 11 mem read.
- State IDLE: on rx_valid, latch op and addr[13:8], go to ADDR.
- State ADDR: on rx_valid, latch addr[7:0]. For a write op go to DATA with byte count 0; for a read op go to RD_WAIT.
- State DATA: on each rx_valid, shift the byte into the data shift register (first byte lands in [31:24]). On the 4th byte go to EXEC.
- State EXEC (one cycle):
  - uart_dout = assembled word; uart_addr = address.
  - Exactly one of reg_we/uart_mem_we pulses high for 1 clk, then return to IDLE.
  - uart_addr and uart_dout hold their values until the next frame updates them.
- State RD_WAIT:
  - uart_addr is driven with the read address from the cycle of entry.
  - uart_mem_re is high for the whole state only for op 11.
  - After RD_LAT clocks, capture uart_mem_i (op 11) or uart_reg_i (op 10) into a 24-bit buffer, then go to TX.
- State TX:
  - Send buffer bytes [23:16], [15:8], [7:0] in order.
  - tx_valid stays high and tx_data stays stable until tx_ready.
  - One byte is accepted per handshake cycle.
  - After the third handshake, tx_valid falls the next clock and the state returns to IDLE.
  - tx_ready=0 indefinitely stalls the block; no timeout applies in TX.
- Overflow: rx_valid in RD_WAIT/TX drops the byte and sets err_ovf. State is unaffected.
- Timeout: in ADDR/DATA, a gap counter clears on every rx_valid and increments otherwise.
  - When it reaches TIMEOUT_CYC-1 without a byte, return to IDLE, set err_tout, and issue no strobe.
  - If rx_valid arrives in the same cycle as the expiry, the byte wins: it is accepted and the counter clears.
- Write-address range: uart_addr is passed unmodified; range decode is downstream.
- Latency: last data byte strobe to write strobe = 1 clk. Second address byte strobe to first tx_valid = RD_LAT+1 clks.
- Bus idle: uart_mem_we, reg_we and uart_mem_re are never asserted together; all three are 0 in IDLE.

Test Plan:
- Reg write: bytes 0x00,0x03,0x00,0x00,0x80,0x05 → reg_we pulse 1 clk with uart_addr=14'h0003, uart_dout=32'h00008005; uart_mem_we stays 0.
- Mem write: bytes 0x41,0x20,0xDE,0xAD,0xBE,0xEF → uart_mem_we pulse, uart_addr=14'h0120, uart_dout=32'hDEADBEEF.
- Mem read, RD_LAT=2: bytes 0xC8,0x05 with uart_mem_i=24'h00ABCD → uart_mem_re high 2 clks, uart_addr=14'h0805; tx bytes 0x00,0xAB,0xCD. Hold tx_ready=0 for 10 clks on the second byte → tx_data stays 0xAB.
- Reg read with a byte sent during TX: bytes 0x80,0x01, then 0x55 while in TX → reg value 24'h001234 returned as 0x00,0x12,0x34; err_ovf=1; next frame parses normally.
- Timeout: bytes 0x00,0x03 then silence ≥ TIMEOUT_CYC → err_tout=1, no write strobe; a following valid write frame executes normally. A byte arriving exactly at expiry is accepted, not aborted.
- Async reset asserted after 3 of 6 write bytes → outputs 0 immediately, no strobe; the following full frame executes correctly.
